// File: rtl/ext_stage.sv
// rtl/ext_stage.sv - registered immediate extender and branch-target stage
// Define EXT_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module ext_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [1:0]        mode,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_out,
  output logic [DATA_W-1:0] con_ba,
  output logic [TAG_W-1:0]  tag_out
);

  localparam int PAD_W = DATA_W - IMM_W;

  logic [DATA_W-1:0] sext, zext, uext, ext_new, ba_new;
  logic              accept, drain, capture;

  always_comb begin
    sext = {{PAD_W{imm[IMM_W-1]}}, imm};
    zext = {{PAD_W{1'b0}}, imm};
    uext = {imm, {PAD_W{1'b0}}};
    case (mode)
      2'b00:   ext_new = zext;
      2'b10:   ext_new = uext;
      default: ext_new = sext;
    endcase
    // Branch offset is always sign-extended, whatever the operand mode.
    ba_new = pc_plus4 + {sext[DATA_W-3:0], 2'b00};
  end

  assign accept  = in_valid && in_ready;
  assign drain   = out_valid && out_ready;
  assign capture = accept && !flush;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] ext_q, ext_d, ba_q, ba_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  assign out_valid = out_valid_q;
  assign ext_out   = ext_q;
  assign con_ba    = ba_q;
  assign tag_out   = tag_q;

`ifdef EXT_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sk_ext_q, sk_ext_d, sk_ba_q, sk_ba_d;
  logic [TAG_W-1:0]  sk_tag_q, sk_tag_d;

  // Depends only on state and reset, never on out_ready.
  assign in_ready = !reset && (state_q != FULL);

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    ba_d     = ba_q;
    tag_d    = tag_q;
    sk_ext_d = sk_ext_q;
    sk_ba_d  = sk_ba_q;
    sk_tag_d = sk_tag_q;
    case (state_q)
      EMPTY: begin
        if (capture) begin
          ext_d   = ext_new;
          ba_d    = ba_new;
          tag_d   = tag_in;
          state_d = ONE;
        end
      end
      ONE: begin
        if (capture && drain) begin
          ext_d = ext_new;
          ba_d  = ba_new;
          tag_d = tag_in;
        end else if (capture) begin
          sk_ext_d = ext_new;
          sk_ba_d  = ba_new;
          sk_tag_d = tag_in;
          state_d  = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          ext_d   = sk_ext_q;
          ba_d    = sk_ba_q;
          tag_d   = sk_tag_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      ext_q       <= '0;
      ba_q        <= '0;
      tag_q       <= '0;
      sk_ext_q    <= '0;
      sk_ba_q     <= '0;
      sk_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ext_q       <= ext_d;
      ba_q        <= ba_d;
      tag_q       <= tag_d;
      sk_ext_q    <= sk_ext_d;
      sk_ba_q     <= sk_ba_d;
      sk_tag_q    <= sk_tag_d;
    end
  end
`else
  assign in_ready = !reset && (!out_valid_q || out_ready);

  always_comb begin
    ext_d       = ext_q;
    ba_d        = ba_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    if (capture) begin
      ext_d       = ext_new;
      ba_d        = ba_new;
      tag_d       = tag_in;
      out_valid_d = 1'b1;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ext_q       <= '0;
      ba_q        <= '0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ext_q       <= ext_d;
      ba_q        <= ba_d;
      tag_q       <= tag_d;
    end
  end
`endif

endmodule
